// File: rtl/pc_seq_unit_if.sv
// Fetch-side bundle between control unit and PC sequencer.
// Control unit drives redirects; the PC unit returns fetch state.
interface pc_seq_unit_if #(
  parameter int AW = 32
);
  logic          pause;
  logic          PcSel;
  logic [AW-1:0] Adress;
  logic          Jump;
  logic [25:0]   Jumpaddr;
  logic          JumpReg;
  logic [AW-1:0] RegAddr;
  logic          Call;
  logic          Ret;
  logic [AW-1:0] PC;
  logic [4:0]    RasDepth;
  logic          Halted;
  logic          RasOvf;
  logic          RasUdf;
  logic          AlignErr;

  modport master (
    output pause, PcSel, Adress, Jump, Jumpaddr,
    output JumpReg, RegAddr, Call, Ret,
    input  PC, RasDepth, Halted,
    input  RasOvf, RasUdf, AlignErr
  );

  modport slave (
    input  pause, PcSel, Adress, Jump, Jumpaddr,
    input  JumpReg, RegAddr, Call, Ret,
    output PC, RasDepth, Halted,
    output RasOvf, RasUdf, AlignErr
  );
endinterface

// File: rtl/pc_seq_unit.sv
// Next-PC sequencer: fixed-priority redirects, limit-gated
// increment and a circular return-address stack.
module pc_seq_unit #(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter logic [AW-1:0] PC_LIMIT  = AW'(32'h6C),
  parameter int            RAS_DEPTH = 4
) (
  input  logic clk,
  input  logic PcReSet,
  pc_seq_unit_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [4:0]    DMAX = 5'(RAS_DEPTH);
  localparam logic [PW-1:0] PMAX = PW'(RAS_DEPTH - 1);

  logic [AW-1:0] pc_q, pc_d;
  logic [4:0]    depth_q, depth_d, depth_pop;
  logic [PW-1:0] sp_q, sp_d, sp_pop, sp_top;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          aln_q, aln_d;
  logic [AW-1:0] ras_q [RAS_DEPTH];
  logic          ras_we;
  logic [PW-1:0] ras_wa;

  logic [AW-1:0] seq, reg_pc, jmp_pc, br_pc;
  logic          empty, pop, push, reg_tgt;

  assign seq    = pc_q + AW'(4);
  assign empty  = (depth_q == 5'd0);
  assign sp_top = (sp_q == '0) ? PMAX : sp_q - PW'(1);
  assign reg_pc = {bus.RegAddr[AW-1:2], 2'b00};
  assign br_pc  = seq + (bus.Adress << 2);

  // Only the low 28 bits come from the J-type index.
  always_comb begin
    jmp_pc        = seq;
    jmp_pc[27:0]  = {bus.Jumpaddr, 2'b00};
  end

  always_comb begin
    pc_d      = pc_q;
    depth_d   = depth_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    aln_d     = aln_q;
    ras_we    = 1'b0;
    ras_wa    = sp_q;
    reg_tgt   = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    sp_pop    = sp_q;
    depth_pop = depth_q;
    if (!bus.pause) begin
      if (bus.Ret) begin
        if (!empty) begin
          pc_d = ras_q[sp_top];
          pop  = 1'b1;
        end else begin
          pc_d    = reg_pc;
          reg_tgt = 1'b1;
          udf_d   = 1'b1;
        end
      end else if (bus.JumpReg) begin
        pc_d    = reg_pc;
        reg_tgt = 1'b1;
      end else if (bus.Jump) begin
        pc_d = jmp_pc;
      end else if (bus.PcSel) begin
        pc_d = br_pc;
      end else if (pc_q < PC_LIMIT) begin
        pc_d = seq;
      end

      if (reg_tgt && bus.RegAddr[1:0] != 2'b00)
        aln_d = 1'b1;

      push = bus.Call &
             (bus.Jump | bus.JumpReg | bus.Ret);

      // Pop first so Call+Ret overwrites the popped top.
      if (pop) begin
        sp_pop    = sp_top;
        depth_pop = depth_q - 5'd1;
      end
      sp_d    = sp_pop;
      depth_d = depth_pop;

      if (push) begin
        ras_we = 1'b1;
        ras_wa = sp_pop;
        sp_d   = (sp_pop == PMAX) ? '0 : sp_pop + PW'(1);
        if (depth_pop == DMAX)
          ovf_d = 1'b1;
        else
          depth_d = depth_pop + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge PcReSet) begin
    if (PcReSet) begin
      pc_q    <= RESET_PC;
      depth_q <= 5'd0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      aln_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      aln_q   <= aln_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we)
      ras_q[ras_wa] <= seq;
  end

  assign bus.PC       = pc_q;
  assign bus.RasDepth = depth_q;
  assign bus.Halted   = (pc_q >= PC_LIMIT);
  assign bus.RasOvf   = ovf_q;
  assign bus.RasUdf   = udf_q;
  assign bus.AlignErr = aln_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: directed table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_pc_seq_unit;
  localparam logic [31:0] LIM = 32'h6C;

  logic clk = 1'b0;
  logic PcReSet;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pc_seq_unit_if #(.AW(32)) bus ();

  pc_seq_unit #(
    .AW(32), .RESET_PC(32'h0),
    .PC_LIMIT(32'h6C), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .PcReSet(PcReSet), .bus(bus)
  );

  logic [31:0] mpc;
  logic [31:0] mras [$];
  logic        movf, mudf, maln;

  typedef struct {
    bit          pause;
    bit          pcsel;
    logic [31:0] adr;
    bit          jump;
    logic [25:0] ja;
    bit          jr;
    logic [31:0] ra;
    bit          call;
    bit          ret;
    logic [31:0] epc;
    int          edep;
    logic [2:0]  eflg;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic idle();
    bus.pause = 0; bus.PcSel = 0; bus.Adress = 0;
    bus.Jump = 0; bus.Jumpaddr = 0; bus.JumpReg = 0;
    bus.RegAddr = 0; bus.Call = 0; bus.Ret = 0;
  endtask

  task automatic model_reset();
    mpc = 32'h0;
    mras.delete();
    movf = 0; mudf = 0; maln = 0;
  endtask

  task automatic model_step();
    logic [31:0] s, nxt;
    if (bus.pause) return;
    s = mpc + 32'd4;
    if (bus.Ret) begin
      if (mras.size() > 0) nxt = mras.pop_back();
      else begin
        nxt = bus.RegAddr & ~32'd3;
        mudf = 1;
        if (bus.RegAddr[1:0] != 0) maln = 1;
      end
    end else if (bus.JumpReg) begin
      nxt = bus.RegAddr & ~32'd3;
      if (bus.RegAddr[1:0] != 0) maln = 1;
    end else if (bus.Jump)
      nxt = {s[31:28], bus.Jumpaddr, 2'b00};
    else if (bus.PcSel)
      nxt = s + (bus.Adress * 32'd4);
    else
      nxt = (mpc < LIM) ? s : mpc;
    if (bus.Call && (bus.Jump || bus.JumpReg || bus.Ret)) begin
      if (mras.size() == 4) begin
        void'(mras.pop_front());
        movf = 1;
      end
      mras.push_back(s);
    end
    mpc = nxt;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_pc"}, bus.PC, mpc);
    chk({nm, "_st"},
        {bus.RasDepth, bus.Halted, bus.RasOvf,
         bus.RasUdf, bus.AlignErr},
        {5'(mras.size()), mpc >= LIM, movf, mudf, maln});
  endtask

  // Async reset raised mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2 PcReSet = 1;
    #1;
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_st",
        {bus.RasDepth, bus.Halted, bus.RasOvf,
         bus.RasUdf, bus.AlignErr}, 9'h0);
    model_reset();
    @(negedge clk);
    PcReSet = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e;
    int a;
    PcReSet = 1;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    PcReSet = 0;
    chk("init_pc", bus.PC, 32'h0);
    chk("init_dep", bus.RasDepth, 5'd0);

    for (int i = 0; i < 30; i++) begin
      step();
      e = (4 * (i + 1) > 32'h6C) ? 32'h6C : 32'(4 * (i + 1));
      chk("seq_pc", bus.PC, e);
      chk("seq_halt", bus.Halted, e >= LIM);
    end

    do_reset();
    for (int i = 0; i < 4; i++) step();
    bus.pause = 1;
    bus.Jump = 1; bus.Jumpaddr = 26'h3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause_pc", bus.PC, 32'h10);
    end
    idle();
    step();
    chk("unpause_pc", bus.PC, 32'h14);

    tbl[0]  = '{0,0,0,0,0,1,32'h20,0,0,32'h20,0,3'b000};
    tbl[1]  = '{0,1,32'hFFFFFFFD,0,0,0,0,0,0,32'h18,0,3'b000};
    tbl[2]  = '{0,0,0,1,26'h10,0,0,0,0,32'h40,0,3'b000};
    tbl[3]  = '{0,1,32'd5,1,26'h4,0,0,0,0,32'h10,0,3'b000};
    tbl[4]  = '{1,0,0,1,26'h30,0,0,1,0,32'h10,0,3'b000};
    tbl[5]  = '{0,0,0,0,0,1,32'h08,0,0,32'h08,0,3'b000};
    tbl[6]  = '{0,0,0,1,26'hC,0,0,1,0,32'h30,1,3'b000};
    tbl[7]  = '{0,0,0,0,0,0,0,0,1,32'h0C,0,3'b000};
    tbl[8]  = '{0,0,0,0,0,0,32'h52,0,1,32'h50,0,3'b011};
    tbl[9]  = '{0,0,0,0,0,0,0,0,0,32'h54,0,3'b011};
    tbl[10] = '{0,1,32'd0,0,0,0,0,0,0,32'h58,0,3'b011};
    tbl[11] = '{0,0,0,0,0,1,32'h6C,0,0,32'h6C,0,3'b011};
    tbl[12] = '{0,0,0,0,0,0,0,0,0,32'h6C,0,3'b011};
    tbl[13] = '{0,0,0,0,0,1,32'h04,0,0,32'h04,0,3'b011};
    tbl[14] = '{0,0,0,0,0,0,0,0,0,32'h08,0,3'b011};
    tbl[15] = '{0,0,0,0,0,0,0,1,0,32'h0C,0,3'b011};
    tbl[16] = '{0,1,32'd1,0,0,0,0,1,0,32'h14,0,3'b011};

    do_reset();
    foreach (tbl[i]) begin
      bus.pause = tbl[i].pause; bus.PcSel = tbl[i].pcsel;
      bus.Adress = tbl[i].adr; bus.Jump = tbl[i].jump;
      bus.Jumpaddr = tbl[i].ja; bus.JumpReg = tbl[i].jr;
      bus.RegAddr = tbl[i].ra; bus.Call = tbl[i].call;
      bus.Ret = tbl[i].ret;
      step();
      chk($sformatf("tbl%0d_pc", i), bus.PC, tbl[i].epc);
      chk($sformatf("tbl%0d_dep", i), bus.RasDepth,
          64'(tbl[i].edep));
      chk($sformatf("tbl%0d_halt", i), bus.Halted,
          tbl[i].epc >= LIM);
      chk($sformatf("tbl%0d_flg", i),
          {bus.RasOvf, bus.RasUdf, bus.AlignErr}, tbl[i].eflg);
    end
    idle();
    do_reset();

    for (int k = 0; k < 5; k++) begin
      bus.Jump = 1; bus.Call = 1;
      bus.Jumpaddr = 26'((k + 1) * 32'h40);
      step();
    end
    idle();
    chk("nest_dep", bus.RasDepth, 5'd4);
    chk("nest_ovf", bus.RasOvf, 1'b1);
    for (int j = 0; j < 4; j++) begin
      bus.Ret = 1;
      step();
      chk("nest_ret_pc", bus.PC, 32'h404 - 32'(j) * 32'h100);
    end
    chk("nest_dep0", bus.RasDepth, 5'd0);
    chk("nest_udf", bus.RasUdf, 1'b0);
    idle();

    do_reset();
    bus.Jump = 1; bus.Call = 1; bus.Jumpaddr = 26'h10;
    step();
    bus.Jumpaddr = 26'h20;
    step();
    chk("cr_pre_pc", bus.PC, 32'h80);
    chk("cr_pre_dep", bus.RasDepth, 5'd2);
    bus.Jump = 0; bus.Ret = 1;
    step();
    chk("cr_pc", bus.PC, 32'h44);
    chk("cr_dep", bus.RasDepth, 5'd2);
    bus.Call = 0;
    step();
    chk("cr_top", bus.PC, 32'h84);
    step();
    chk("cr_bot", bus.PC, 32'h04);
    chk("cr_dep0", bus.RasDepth, 5'd0);
    bus.Call = 1;
    step();
    chk("cr_empty_dep", bus.RasDepth, 5'd1);
    chk("cr_empty_udf", bus.RasUdf, 1'b1);
    idle();

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        idle();
        do_reset();
        chk_model("rand_rst");
      end
      bus.pause    = ($urandom_range(0, 9) == 0);
      bus.Ret      = ($urandom_range(0, 7) == 0);
      bus.JumpReg  = ($urandom_range(0, 9) == 0);
      bus.Jump     = ($urandom_range(0, 7) == 0);
      bus.PcSel    = ($urandom_range(0, 4) == 0);
      bus.Call     = ($urandom_range(0, 2) == 0);
      bus.RegAddr  = $urandom_range(0, 127);
      bus.Jumpaddr = 26'($urandom_range(0, 40));
      a = int'($urandom_range(0, 16)) - 8;
      bus.Adress   = a;
      step();
      chk_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
